// File: rtl/sub_share_pkg.sv
// Shared types and helpers for the SUB-unit sharing arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package sub_share_pkg;

    // Transaction phases of the arbiter FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Increment an index modulo n, with an explicit wrap so that
    // non-power-of-2 requester counts do not land on unused indices.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sub_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, with wrap.
// Latency: purely combinational.
// Backpressure: none, the caller decides when to use the result.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] rr_ptr_i,
    output logic            found_o,
    output logic [IDXW-1:0] idx_o
);

    int unsigned     p;
    logic [IDXW-1:0] pos;

    // Scan NREQ positions starting at the pointer; the first hit wins
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        p       = 0;
        pos     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            p = 32'(rr_ptr_i) + k;
            if (p >= NREQ) begin
                p = p - NREQ;
            end
            pos = IDXW'(p);
            if (!found_o && req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin sharing of one SUB unit among NREQ requesters, with timeout.
// Latency: req -> grant/issue 1 cycle; unit result -> done 1 cycle.
// Backpressure: requesters hold req/req_data until their one-cycle done pulse.
module sub_share_arbiter
    import sub_share_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  unit_in_valid,
    output logic [WIDTH-1:0]      unit_in_data,
    input  logic                  unit_out_valid,
    input  logic [WIDTH-1:0]      unit_out_data
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              resp_err_q, resp_err_d;
    logic              busy_q, busy_d;
    logic              uiv_q, uiv_d;
    logic [WIDTH-1:0]  uid_q, uid_d;

    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;
    logic [WIDTH-1:0]  ops [NREQ];

    // Unpack the per-requester operands for indexed selection
    for (genvar i = 0; i < NREQ; i++) begin : g_ops
        assign ops[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    // State and output registers; reset abandons any transaction silently
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            result_q   <= '0;
            resp_err_q <= 1'b0;
            busy_q     <= 1'b0;
            uiv_q      <= 1'b0;
            uid_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            result_q   <= result_d;
            resp_err_q <= resp_err_d;
            busy_q     <= busy_d;
            uiv_q      <= uiv_d;
            uid_q      <= uid_d;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so they come out registered
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        done_d     = '0;
        result_d   = result_q;
        resp_err_d = resp_err_q;
        busy_d     = busy_q;
        uiv_d      = 1'b0;
        uid_d      = uid_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d          = ISSUE;
                    idx_d            = pick_idx;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    uiv_d            = 1'b1;
                    uid_d            = ops[pick_idx];
                    busy_d           = 1'b1;
                end
            end
            ISSUE: begin
                // A unit result during the issue cycle is not for us yet
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A valid result in the timeout cycle still wins over the error
                if (unit_out_valid) begin
                    state_d       = RESP;
                    result_d      = unit_out_data;
                    resp_err_d    = 1'b0;
                    done_d[idx_q] = 1'b1;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    result_d      = '0;
                    resp_err_d    = 1'b1;
                    done_d[idx_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            RESP: begin
                // The served requester drops to lowest priority next round
                state_d    = IDLE;
                grant_d    = '0;
                resp_err_d = 1'b0;
                busy_d     = 1'b0;
                rr_ptr_d   = IDXW'(wrap_inc(32'(idx_q), NREQ));
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant         = grant_q;
    assign done          = done_q;
    assign result        = result_q;
    assign resp_err      = resp_err_q;
    assign busy          = busy_q;
    assign unit_in_valid = uiv_q;
    assign unit_in_data  = uid_q;

endmodule
